// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes and debounces one push-button line, producing a
// clean level, one-cycle press/release strobes and an 8-bit press count.
// Optional macro KEY_LONGPRESS_EN adds a hold counter and a long_press strobe;
// without it long_press is a constant 0.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic [7:0] press_count,
    output logic       long_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic REL_LEVEL = (ACTIVE_LOW != 0);

    typedef enum logic {UP, DOWN} state_t;

    state_t state, state_d;
    logic sync1, sync2, k;
    logic [CW-1:0] cnt, cnt_d;
    logic press_fire, rel_fire;

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_params
        $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    // two-flop synchronizer, reset to the released pin level so reset never looks like a press
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1 <= REL_LEVEL;
            sync2 <= REL_LEVEL;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    assign k = sync2 ^ REL_LEVEL;
    assign key_level = (state == DOWN);

    // state, debounce counter, strobes and press count
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= UP;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            key_press   <= press_fire;
            key_release <= rel_fire;
            press_count <= press_count + {7'd0, press_fire};
        end
    end

    // next state: accept a new level once it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        state_d    = state;
        press_fire = 1'b0;
        rel_fire   = 1'b0;
        cnt_d      = (k != key_level) ? cnt + CW'(1) : '0;
        if (state == UP && k && cnt == DB_MAX) begin
            state_d    = DOWN;
            press_fire = 1'b1;
            cnt_d      = '0;
        end
        if (state == DOWN && !k && cnt == DB_MAX) begin
            state_d  = UP;
            rel_fire = 1'b1;
            cnt_d    = '0;
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold;

    // hold counter restarts on each accepted press and saturates, giving one strobe per press
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            hold       <= press_fire ? '0 : (state == DOWN && hold < HOLD_MAX) ? hold + HW'(1) : hold;
            long_press <= (state == DOWN) && (hold == HOLD_MAX - HW'(1));
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
Input-side companion to the LED blink logic. It reads one raw push-button line, such as a board KEY, and produces a clean debounced level plus single-cycle press and release strobes. It also keeps a running press count. Timing is derived from the 50 MHz board clock, the same way the LED toggle timing is. The block sits between the board pins and the control logic that drives the LEDs.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of consecutive cycles the synchronized input must differ from the stable level before the level is accepted (20 ms at 50 MHz); minimum 2.
LONG_CYCLES, 50000000, cycles the key must stay debounced-pressed before long_press fires (1 s); used only with KEY_LONGPRESS_EN.
ACTIVE_LOW, 1, 1 means the KEY pin reads 0 when pressed (board pushbuttons); 0 means it reads 1 when pressed.

Ports:
CLOCK_50  input  1  system clock, 50 MHz; sole clock.
RESET  input  1  synchronous, active-high reset.
KEY  input  1  raw asynchronous button pin.
key_level  output  1  debounced level; 1 = pressed.
key_press  output  1  one-cycle pulse on an accepted press.
key_release  output  1  one-cycle pulse on an accepted release.
press_count  output  8  number of accepted presses, modulo 256.
long_press  output  1  one-cycle pulse after a sustained hold; tied to 0 without the macro.

Behaviour:
- One clock, CLOCK_50. RESET is synchronous and active-high; it is sampled only on the rising edge of CLOCK_50.
- Reset values: key_level=0, key_press=0, key_release=0, press_count=0, long_press=0.
  - Both synchronizer flops load the released pin level (1 if ACTIVE_LOW, else 0).
  - Debounce counter and hold counter load 0. State loads UP.
- Input path: 2-flop synchronizer on KEY. Normalized input k = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - Increments each cycle that k != key_level.
  - Clears to 0 in any cycle where k == key_level, so any bounce restarts the count.
  - It never exceeds DEBOUNCE_CYCLES-1.
- State machine, 2 states:
  - UP: when k=1 and counter == DEBOUNCE_CYCLES-1, go to DOWN on the next edge. On that same edge: key_level<=1, key_press<=1, press_count<=press_count+1, counter<=0.
  - DOWN: when k=0 and counter == DEBOUNCE_CYCLES-1, go to UP on the next edge. On that same edge: key_level<=0, key_release<=1, counter<=0.
- key_press and key_release are high for exactly one cycle and are never high together.
- Latency: a clean input change at the pin is reflected on key_level, together with its pulse, exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new pin value.
- press_count wraps 255 -> 0 with no flag.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no output change.
- Reset mid-operation:
  - Every output returns to its reset value on the next edge. No pulse is emitted on reset entry or exit.
  - A key held through reset deassertion must be re-qualified: DEBOUNCE_CYCLES+2 cycles after RESET falls, key_press fires and press_count becomes 1.
- RESET has priority over all other events in the same cycle.

Optional Feature:
KEY_LONGPRESS_EN
- Defined: adds a hold counter of width $clog2(LONG_CYCLES+1).
  - The counter clears on entry to DOWN and increments every cycle in DOWN while it is below LONG_CYCLES.
  - long_press pulses for one cycle on the edge where the hold counter reaches LONG_CYCLES.
  - At most one long_press per press. It re-arms only after an accepted release.
  - Leaving DOWN before the count completes gives no long_press.
  - press_count is unaffected by long presses.
- Undefined: no hold counter is built, and long_press is a constant 0.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
1. Reset: RESET=1 for 2 cycles with KEY=1 -> key_level=0, key_press=0, key_release=0, long_press=0, press_count=0.
2. Clean press: KEY 1->0 and held -> key_level=1 and a single key_press exactly 6 edges later; press_count=1.
3. Bounce: KEY low 3 cycles, high 1, low 3, high 1, then low and held.
   - No key_press during the bounce.
   - Exactly one key_press 6 edges after the final falling transition.
4. Release: after step 2, KEY 0->1 -> key_release one cycle and key_level=0 exactly 6 edges later; press_count unchanged.
5. Wrap and reset mid-press: 256 clean presses -> press_count=0. Then hold KEY=0, pulse RESET for 1 cycle -> outputs cleared; key_press fires again 6 edges after RESET falls; press_count=1.
6. Long press: hold KEY low for 40 cycles.
   - With KEY_LONGPRESS_EN: one long_press exactly 20 edges after key_level rises, none afterwards. A hold of only 10 cycles -> no long_press.
   - Without the macro: long_press stays 0 throughout.
